// File: rtl/alu_issue_pkg.sv
// Shared opcode encodings, flag bit positions and issue payload for the ALU
// and its issue/writeback front end.
package alu_issue_pkg;

  localparam int unsigned OP_W   = 7;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned FLAG_W = 7;

  localparam logic [OP_W-1:0] MATH_ADD = 7'd1;
  localparam logic [OP_W-1:0] MATH_SUB = 7'd2;
  localparam logic [OP_W-1:0] MATH_AND = 7'd3;
  localparam logic [OP_W-1:0] MATH_OR  = 7'd4;
  localparam logic [OP_W-1:0] MATH_XOR = 7'd5;
  localparam logic [OP_W-1:0] MATH_CMP = 7'd6;
  localparam logic [OP_W-1:0] MATH_DIV = 7'd7;
  localparam logic [OP_W-1:0] MATH_MOD = 7'd8;

  // Flag packing, bit 6 down to bit 0: {undef, lt, eq, ovf, carry, one, zero}
  localparam int unsigned FLAG_ZERO  = 0;
  localparam int unsigned FLAG_ONE   = 1;
  localparam int unsigned FLAG_CARRY = 2;
  localparam int unsigned FLAG_OVF   = 3;
  localparam int unsigned FLAG_EQ    = 4;
  localparam int unsigned FLAG_LT    = 5;
  localparam int unsigned FLAG_UNDEF = 6;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              sgn;
  } issue_t;

  function automatic logic is_divide(input logic [OP_W-1:0] op);
    return (op == MATH_DIV) || (op == MATH_MOD);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 8-bit ALU. Divide/modulo by zero and unknown opcodes return 0
// with the undefined flag set; in unsigned mode overflow mirrors carry/borrow.
module alu
  import alu_issue_pkg::*;
(
  input  logic [DATA_W-1:0] i_A,
  input  logic [DATA_W-1:0] i_B,
  input  logic [OP_W-1:0]   i_op,
  input  logic              i_signed,
  output logic [DATA_W-1:0] o_G,
  output logic [FLAG_W-1:0] o_flags
);

  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic              add_sovf;
  logic              sub_sovf;
  logic              less;
  logic [DATA_W-1:0] g;
  logic              carry;
  logic              ovf;
  logic              undef;

  assign sum      = {1'b0, i_A} + {1'b0, i_B};
  assign diff     = {1'b0, i_A} - {1'b0, i_B};
  assign add_sovf = (i_A[DATA_W-1] == i_B[DATA_W-1]) && (sum[DATA_W-1] != i_A[DATA_W-1]);
  assign sub_sovf = (i_A[DATA_W-1] != i_B[DATA_W-1]) && (diff[DATA_W-1] != i_A[DATA_W-1]);
  assign less     = i_signed ? ($signed(i_A) < $signed(i_B)) : (i_A < i_B);

  always_comb begin
    g     = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    undef = 1'b0;
    case (i_op)
      MATH_ADD: begin
        g     = sum[DATA_W-1:0];
        carry = sum[DATA_W];
        ovf   = i_signed ? add_sovf : sum[DATA_W];
      end
      MATH_SUB, MATH_CMP: begin
        g     = diff[DATA_W-1:0];
        carry = diff[DATA_W];
        ovf   = i_signed ? sub_sovf : diff[DATA_W];
      end
      MATH_AND: g = i_A & i_B;
      MATH_OR:  g = i_A | i_B;
      MATH_XOR: g = i_A ^ i_B;
      MATH_DIV: begin
        if (i_B == '0) undef = 1'b1;
        else           g = i_A / i_B;
      end
      MATH_MOD: begin
        if (i_B == '0) undef = 1'b1;
        else           g = i_A % i_B;
      end
      default: undef = 1'b1;
    endcase
  end

  always_comb begin
    o_flags             = '0;
    o_flags[FLAG_ZERO]  = (g == '0);
    o_flags[FLAG_ONE]   = (g == 8'd1);
    o_flags[FLAG_CARRY] = carry;
    o_flags[FLAG_OVF]   = ovf;
    o_flags[FLAG_EQ]    = (i_A == i_B);
    o_flags[FLAG_LT]    = less;
    o_flags[FLAG_UNDEF] = undef;
  end

  assign o_G = g;

endmodule

// File: rtl/alu_issue_stage.sv
// One-entry valid/ready pipeline register. The payload is only written on a
// load, so it keeps its last value after the entry drains.
module alu_issue_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_reg;
  logic         valid_next;
  logic [W-1:0] data_reg;
  logic [W-1:0] data_next;

  // A full entry that is leaving this cycle can take a new one in its place.
  assign in_ready = !valid_reg || out_ready;

  always_comb begin
    valid_next = valid_reg;
    data_next  = data_reg;
    if (in_valid && in_ready) begin
      valid_next = 1'b1;
      data_next  = in_data;
    end else if (out_ready) begin
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else begin
      valid_reg <= valid_next;
      data_reg  <= data_next;
    end
  end

  assign out_valid = valid_reg;
  assign out_data  = data_reg;

endmodule

// File: rtl/alu_issue.sv
// Two-stage issue/writeback front end for the combinational ALU: registered
// issue stage, writeback stage with backpressure, status register and fault.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int DEST_W = 3
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [OP_W-1:0]   i_req_op,
  input  logic [DATA_W-1:0] i_req_a,
  input  logic [DATA_W-1:0] i_req_b,
  input  logic              i_req_signed,
  input  logic [DEST_W-1:0] i_req_dest,
  output logic [DATA_W-1:0] o_alu_a,
  output logic [DATA_W-1:0] o_alu_b,
  output logic [OP_W-1:0]   o_alu_op,
  output logic              o_alu_signed,
  input  logic [DATA_W-1:0] i_alu_g,
  input  logic [FLAG_W-1:0] i_alu_flags,
  output logic              o_wb_valid,
  input  logic              i_wb_ready,
  output logic [DATA_W-1:0] o_wb_data,
  output logic [DEST_W-1:0] o_wb_dest,
  output logic [FLAG_W-1:0] o_status,
  output logic              o_fault,
  input  logic              i_fault_clr,
  output logic [7:0]        o_issue_count
);

  localparam int S1_W = $bits(issue_t) + DEST_W;
  localparam int S2_W = DATA_W + DEST_W;

  logic              fault_reg;
  logic              fault_next;
  logic [FLAG_W-1:0] status_reg;
  logic [FLAG_W-1:0] status_next;
  logic [7:0]        count_reg;
  logic [7:0]        count_next;

  logic              accept_en;
  logic              s1_in_valid;
  logic              s1_in_ready;
  logic              s1_valid;
  logic              s1_out_ready;
  logic [S1_W-1:0]   s1_in;
  logic [S1_W-1:0]   s1_data;
  issue_t            s1_req;
  logic [DEST_W-1:0] s1_dest;

  logic              s2_in_valid;
  logic              s2_in_ready;
  logic [S2_W-1:0]   s2_in;
  logic [S2_W-1:0]   s2_data;

  logic              retire;
  logic              div_fault;
  logic              writes_back;

  // No request is taken while faulted or during the clearing cycle itself.
  assign accept_en   = !fault_reg && !i_fault_clr;
  assign s1_in_valid = i_req_valid && accept_en;
  assign o_req_ready = accept_en && s1_in_ready;
  assign s1_in       = {i_req_op, i_req_a, i_req_b, i_req_signed, i_req_dest};

  alu_issue_stage #(.W(S1_W)) u_stage1 (
    .clk       (i_clk),
    .srst      (i_reset),
    .in_valid  (s1_in_valid),
    .in_ready  (s1_in_ready),
    .in_data   (s1_in),
    .out_valid (s1_valid),
    .out_ready (s1_out_ready),
    .out_data  (s1_data)
  );

  assign {s1_req, s1_dest} = s1_data;

  assign o_alu_a      = s1_req.a;
  assign o_alu_b      = s1_req.b;
  assign o_alu_op     = s1_req.op;
  assign o_alu_signed = s1_req.sgn;

  // Stage 1 may leave even for ops that skip stage 2, but only when stage 2
  // could have accepted a result, which keeps retire order simple.
  assign s1_out_ready = !fault_reg && s2_in_ready;
  assign retire       = s1_valid && s1_out_ready;
  assign div_fault    = is_divide(s1_req.op) && i_alu_flags[FLAG_UNDEF];
  assign writes_back  = !div_fault && (s1_req.op != MATH_CMP);
  assign s2_in_valid  = retire && writes_back;
  assign s2_in        = {i_alu_g, s1_dest};

  alu_issue_stage #(.W(S2_W)) u_stage2 (
    .clk       (i_clk),
    .srst      (i_reset),
    .in_valid  (s2_in_valid),
    .in_ready  (s2_in_ready),
    .in_data   (s2_in),
    .out_valid (o_wb_valid),
    .out_ready (i_wb_ready),
    .out_data  (s2_data)
  );

  assign {o_wb_data, o_wb_dest} = s2_data;

  // A divide fault raised on the same edge as a clear wins, so it is not lost.
  always_comb begin
    status_next = status_reg;
    count_next  = count_reg;
    fault_next  = fault_reg;
    if (retire) begin
      status_next = i_alu_flags;
      count_next  = count_reg + 8'd1;
    end
    if (retire && div_fault) fault_next = 1'b1;
    else if (i_fault_clr)    fault_next = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      fault_reg  <= 1'b0;
      status_reg <= '0;
      count_reg  <= '0;
    end else begin
      fault_reg  <= fault_next;
      status_reg <= status_next;
      count_reg  <= count_next;
    end
  end

  assign o_status      = status_reg;
  assign o_fault       = fault_reg;
  assign o_issue_count = count_reg;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue closed around the alu: directed scenarios
// plus a randomized run, with a writeback scoreboard checked by a monitor.
module tb_alu_issue;
  import alu_issue_pkg::*;

  localparam int DEST_W = 3;

  logic              clk = 1'b0;
  logic              i_reset = 1'b1;
  logic              i_req_valid = 1'b0;
  logic              o_req_ready;
  logic [6:0]        i_req_op = '0;
  logic [7:0]        i_req_a = '0;
  logic [7:0]        i_req_b = '0;
  logic              i_req_signed = 1'b0;
  logic [DEST_W-1:0] i_req_dest = '0;
  logic [7:0]        alu_a, alu_b, alu_g;
  logic [6:0]        alu_op, alu_flags;
  logic              alu_signed;
  logic              o_wb_valid;
  logic              i_wb_ready = 1'b0;
  logic [7:0]        o_wb_data;
  logic [DEST_W-1:0] o_wb_dest;
  logic [6:0]        o_status;
  logic              o_fault;
  logic              i_fault_clr = 1'b0;
  logic [7:0]        o_issue_count;

  always #5 clk = ~clk;

  alu_issue #(.DEST_W(DEST_W)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_op(i_req_op), .i_req_a(i_req_a), .i_req_b(i_req_b),
    .i_req_signed(i_req_signed), .i_req_dest(i_req_dest),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op), .o_alu_signed(alu_signed),
    .i_alu_g(alu_g), .i_alu_flags(alu_flags),
    .o_wb_valid(o_wb_valid), .i_wb_ready(i_wb_ready),
    .o_wb_data(o_wb_data), .o_wb_dest(o_wb_dest),
    .o_status(o_status), .o_fault(o_fault), .i_fault_clr(i_fault_clr),
    .o_issue_count(o_issue_count)
  );

  alu u_alu (
    .i_A(alu_a), .i_B(alu_b), .i_op(alu_op), .i_signed(alu_signed),
    .o_G(alu_g), .o_flags(alu_flags)
  );

  typedef struct {
    logic [7:0]        data;
    logic [DEST_W-1:0] dest;
  } wb_t;

  int         checks = 0;
  int         fails = 0;
  wb_t        sb_q[$];
  logic [6:0] exp_status = '0;
  int         exp_count = 0;
  int         wb_fires = 0;

  logic [6:0]        st_op[0:299];
  logic [7:0]        st_a[0:299];
  logic [7:0]        st_b[0:299];
  logic              st_s[0:299];
  logic [DEST_W-1:0] st_dest[0:299];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference ALU from integer arithmetic on the operand values.
  function automatic void ref_alu(input logic [6:0] op, input logic [7:0] a, input logic [7:0] b,
                                  input logic s, output logic [7:0] g, output logic [6:0] f);
    int ua, ub, sa, sbv, r, sr;
    logic c, v, u;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sbv = int'($signed(b));
    r = 0; sr = 0; c = 1'b0; v = 1'b0; u = 1'b0;
    case (op)
      MATH_ADD: begin
        r = ua + ub; sr = sa + sbv; c = (r > 255);
        v = s ? (sr > 127 || sr < -128) : c;
      end
      MATH_SUB, MATH_CMP: begin
        r = ua - ub; sr = sa - sbv; c = (ua < ub);
        v = s ? (sr > 127 || sr < -128) : c;
      end
      MATH_AND: r = ua & ub;
      MATH_OR:  r = ua | ub;
      MATH_XOR: r = ua ^ ub;
      MATH_DIV: if (ub == 0) u = 1'b1; else r = ua / ub;
      MATH_MOD: if (ub == 0) u = 1'b1; else r = ua % ub;
      default:  u = 1'b1;
    endcase
    g = r[7:0];
    f = '0;
    f[FLAG_ZERO]  = (g == 0);
    f[FLAG_ONE]   = (g == 1);
    f[FLAG_CARRY] = c;
    f[FLAG_OVF]   = v;
    f[FLAG_EQ]    = (ua == ub);
    f[FLAG_LT]    = s ? (sa < sbv) : (ua < ub);
    f[FLAG_UNDEF] = u;
  endfunction

  task automatic model_accept(input int i);
    logic [7:0] g;
    logic [6:0] f;
    ref_alu(st_op[i], st_a[i], st_b[i], st_s[i], g, f);
    exp_status = f;
    exp_count  = (exp_count + 1) % 256;
    if (!(((st_op[i] == MATH_DIV) || (st_op[i] == MATH_MOD)) && f[FLAG_UNDEF]) && st_op[i] != MATH_CMP)
      sb_q.push_back('{data: g, dest: st_dest[i]});
  endtask

  task automatic set_op(input int i, input logic [6:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic [DEST_W-1:0] d);
    st_op[i] = op; st_a[i] = a; st_b[i] = b; st_s[i] = s; st_dest[i] = d;
  endtask

  // Offers st[start..n-1] in order, at most max_cycles cycles; entered and left at posedge+1.
  task automatic drive_stream(input int start, input int n, input int max_cycles,
                              input bit rand_wb, output int next_idx);
    int   idx;
    logic rdy;
    idx = start;
    for (int cyc = 0; cyc < max_cycles && idx < n; cyc++) begin
      i_req_valid  = 1'b1;
      i_req_op     = st_op[idx];
      i_req_a      = st_a[idx];
      i_req_b      = st_b[idx];
      i_req_signed = st_s[idx];
      i_req_dest   = st_dest[idx];
      if (rand_wb) i_wb_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      rdy = o_req_ready;
      @(posedge clk);
      if (rdy) begin
        model_accept(idx);
        idx++;
      end
      #1;
    end
    i_req_valid = 1'b0;
    next_idx = idx;
  endtask

  task automatic drain(input string tag);
    bit done;
    done = 1'b0;
    i_req_valid = 1'b0;
    i_wb_ready  = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk); #1;
      if (sb_q.size() == 0 && !o_wb_valid) done = 1'b1;
    end
    check({"drain_", tag}, sb_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, o_req_ready, 1);
    check({tag, "_wb_valid"}, o_wb_valid, 0);
    check({tag, "_wb_data"}, o_wb_data, 0);
    check({tag, "_wb_dest"}, o_wb_dest, 0);
    check({tag, "_alu_a"}, alu_a, 0);
    check({tag, "_alu_b"}, alu_b, 0);
    check({tag, "_alu_op"}, alu_op, 0);
    check({tag, "_alu_signed"}, alu_signed, 0);
    check({tag, "_status"}, o_status, 0);
    check({tag, "_fault"}, o_fault, 0);
    check({tag, "_count"}, o_issue_count, 0);
  endtask

  // Entered at posedge+1; holds reset for the given cycles, then checks outputs.
  task automatic apply_reset(input int cycles, input string tag);
    i_reset = 1'b1;
    i_req_valid = 1'b0;
    sb_q.delete();
    exp_count = 0;
    exp_status = '0;
    repeat (cycles) @(posedge clk);
    #1 i_reset = 1'b0;
    @(negedge clk);
    check_reset_outputs(tag);
    @(posedge clk); #1;
  endtask

  // Writeback monitor: scoreboard pops and hold-under-backpressure checks.
  initial begin
    bit         prev_stall;
    logic [7:0] prev_data;
    wb_t        e;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (i_reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("wb_hold_valid", o_wb_valid, 1);
          check("wb_hold_data", o_wb_data, prev_data);
        end
        if (o_wb_valid && i_wb_ready) begin
          wb_fires++;
          if (sb_q.size() == 0) begin
            check("wb_unexpected", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check("wb_data", o_wb_data, e.data);
            check("wb_dest", o_wb_dest, e.dest);
          end
        end
        prev_stall = o_wb_valid && !i_wb_ready;
        prev_data  = o_wb_data;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    int nx, nx2, fire0;

    // Reset state
    #1;
    apply_reset(2, "rst0");

    // ADD 200+100 unsigned: result 44 with carry and overflow
    i_wb_ready = 1'b1;
    set_op(0, MATH_ADD, 8'd200, 8'd100, 1'b0, 3'd3);
    drive_stream(0, 1, 4, 1'b0, nx);
    check("add_accept", nx, 1);
    @(negedge clk);
    check("add_wb_early", o_wb_valid, 0);
    check("add_alu_a", alu_a, 200);
    check("add_alu_b", alu_b, 100);
    check("add_alu_op", alu_op, MATH_ADD);
    @(negedge clk);
    check("add_wb_valid", o_wb_valid, 1);
    check("add_wb_data", o_wb_data, 44);
    check("add_wb_dest", o_wb_dest, 3);
    check("add_carry", o_status[FLAG_CARRY], 1);
    check("add_ovf", o_status[FLAG_OVF], 1);
    @(posedge clk); #1;
    drain("add");

    // SUB 5-5 then CMP 3 vs 9
    apply_reset(1, "rst1");
    i_wb_ready = 1'b1;
    set_op(0, MATH_SUB, 8'd5, 8'd5, 1'b0, 3'd1);
    set_op(1, MATH_CMP, 8'd3, 8'd9, 1'b0, 3'd2);
    drive_stream(0, 2, 4, 1'b0, nx);
    check("subcmp_accept", nx, 2);
    @(negedge clk);
    check("sub_zero", o_status[FLAG_ZERO], 1);
    check("sub_eq", o_status[FLAG_EQ], 1);
    check("sub_wb_data", o_wb_data, 0);
    @(negedge clk);
    check("cmp_lt", o_status[FLAG_LT], 1);
    check("cmp_eq", o_status[FLAG_EQ], 0);
    check("cmp_no_wb", o_wb_valid, 0);
    check("cmp_count", o_issue_count, 2);
    @(posedge clk); #1;
    drain("subcmp");

    // DIV 7/0 faults; clear; DIV 7/2
    set_op(0, MATH_DIV, 8'd7, 8'd0, 1'b0, 3'd4);
    drive_stream(0, 1, 4, 1'b0, nx);
    @(negedge clk);
    @(negedge clk);
    check("div0_fault", o_fault, 1);
    check("div0_undef", o_status[FLAG_UNDEF], 1);
    check("div0_ready", o_req_ready, 0);
    check("div0_no_wb", o_wb_valid, 0);
    check("div0_count", o_issue_count, exp_count[7:0]);
    @(posedge clk); #1;
    i_fault_clr = 1'b1;
    i_req_valid = 1'b1;
    i_req_op = MATH_DIV; i_req_a = 8'd7; i_req_b = 8'd2; i_req_dest = 3'd5;
    @(negedge clk);
    check("clr_cycle_ready", o_req_ready, 0);
    @(posedge clk); #1;
    i_fault_clr = 1'b0;
    i_req_valid = 1'b0;
    @(negedge clk);
    check("clr_fault", o_fault, 0);
    check("clr_ready", o_req_ready, 1);
    check("clr_keeps_status", o_status[FLAG_UNDEF], 1);
    @(posedge clk); #1;
    set_op(0, MATH_DIV, 8'd7, 8'd2, 1'b0, 3'd5);
    drive_stream(0, 1, 4, 1'b0, nx);
    @(negedge clk);
    @(negedge clk);
    check("div_wb_data", o_wb_data, 3);
    @(posedge clk); #1;
    // A clear pulse with no fault pending still blocks acceptance
    i_fault_clr = 1'b1;
    i_req_valid = 1'b1;
    i_req_op = MATH_ADD; i_req_a = 8'd1; i_req_b = 8'd1; i_req_dest = 3'd6;
    @(negedge clk);
    check("clr_idle_ready", o_req_ready, 0);
    @(posedge clk); #1;
    i_fault_clr = 1'b0;
    i_req_valid = 1'b0;
    drain("div");
    check("div_status", o_status, exp_status);

    // Backpressure: 4 ADDs with writeback stalled
    i_wb_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      set_op(i, MATH_ADD, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0, DEST_W'(i));
    drive_stream(0, 4, 6, 1'b0, nx);
    check("bp_accepted", nx, 2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_alu_a", alu_a, st_a[1]);
      check("bp_alu_b", alu_b, st_b[1]);
      check("bp_ready", o_req_ready, 0);
    end
    @(posedge clk); #1;
    i_wb_ready = 1'b1;
    fire0 = wb_fires;
    drive_stream(2, 4, 4, 1'b0, nx2);
    check("bp_resume", nx2, 4);
    @(negedge clk); #1;
    @(negedge clk); #1;
    check("bp_back_to_back", wb_fires - fire0, 4);
    @(negedge clk);
    check("bp_idle", o_wb_valid, 0);
    @(posedge clk); #1;
    drain("bp");

    // Reset with both stages full
    i_wb_ready = 1'b0;
    set_op(0, MATH_ADD, 8'd10, 8'd20, 1'b0, 3'd1);
    set_op(1, MATH_XOR, 8'hF0, 8'h0F, 1'b0, 3'd2);
    drive_stream(0, 2, 4, 1'b0, nx);
    check("midrst_accept", nx, 2);
    i_wb_ready = 1'b1;
    apply_reset(1, "rst_mid");
    repeat (3) @(posedge clk);
    #1;
    check("midrst_no_wb", sb_q.size(), 0);

    // 256 random ops with random backpressure: counter wraps to 0
    apply_reset(1, "rst2");
    for (int i = 0; i < 256; i++) begin
      logic [6:0] op;
      logic [7:0] b;
      op = 7'($urandom_range(0, 10));
      b  = 8'($urandom_range(0, 255));
      if ((op == MATH_DIV || op == MATH_MOD) && b == 0) b = 8'd1;
      set_op(i, op, 8'($urandom_range(0, 255)), b, 1'($urandom_range(0, 1)),
             DEST_W'($urandom_range(0, 7)));
    end
    drive_stream(0, 256, 3000, 1'b1, nx);
    check("rand_accepted", nx, 256);
    drain("rand");
    check("rand_count_wrap", o_issue_count, exp_count[7:0]);
    check("rand_status", o_status, exp_status);
    check("rand_fault", o_fault, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
